// File: rtl/sys_defs.sv
// Shared machine-wide definitions: issue width, functional-unit counts,
// unit latencies, instruction category and the reservation-station entry.
package sys_defs;

    localparam int N           = 3;
    localparam int NUM_FU_ALU  = 3;
    localparam int NUM_FU_MULT = 1;
    localparam int NUM_FU_BR   = 1;
    localparam int NUM_FU_MEM  = 1;
    localparam int MULT_LAT    = 4;

    typedef enum logic [2:0] {
        CAT_ALU    = 3'd0,
        CAT_CSR    = 3'd1,
        CAT_MULT   = 3'd2,
        CAT_BRANCH = 3'd3,
        CAT_MEM    = 3'd4
    } fu_cat_e;

    typedef struct packed {
        fu_cat_e    cat;
        logic [7:0] tag;
    } RS_ENTRY;

endpackage

// File: rtl/fu_busy_tracker.sv
// Occupancy tracker for one non-pipelined unit.
// IS_MULT=1: down-counter loaded with LAT on allocation, cleared by flush.
// IS_MULT=0: busy flag set on allocation, cleared by done; flush ignored
//            because an outstanding memory access must still complete.
module fu_busy_tracker #(
    parameter bit IS_MULT = 1'b1,
    parameter int LAT     = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic alloc,
    input  logic flush,
    input  logic done,
    output logic avail
);

    localparam int CW = $clog2(LAT + 1);

    logic [CW-1:0] cnt;

    // Occupancy state: load on allocation, then count down or wait for done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (alloc) begin
            cnt <= IS_MULT ? CW'(LAT) : CW'(1);
        end else if (IS_MULT && flush) begin
            cnt <= '0;
        end else if (IS_MULT && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end else if (!IS_MULT && done) begin
            cnt <= '0;
        end
    end

    // Availability comes from registered state only.
    assign avail = (cnt == '0);

endmodule

// File: rtl/issue_fu_alloc.sv
// Functional-unit allocator: steers up to N issued instructions per cycle to
// free ALU / MULT / branch / MEM units in slot order and registers the
// per-unit requests. A slot with no free unit is dropped and flagged.
module issue_fu_alloc #(
    parameter int N        = sys_defs::N,
    parameter int NUM_ALU  = sys_defs::NUM_FU_ALU,
    parameter int NUM_MULT = sys_defs::NUM_FU_MULT,
    parameter int NUM_BR   = sys_defs::NUM_FU_BR,
    parameter int NUM_MEM  = sys_defs::NUM_FU_MEM,
    parameter int MULT_LAT = sys_defs::MULT_LAT
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N-1:0]                     issue_valid,
    input  sys_defs::RS_ENTRY [N-1:0]        issued_entries,
    input  logic                             mispredict,
    input  logic [NUM_MEM-1:0]               mem_done,
    output logic [NUM_ALU-1:0]               alu_valid,
    output sys_defs::RS_ENTRY [NUM_ALU-1:0]  alu_entry,
    output logic [NUM_MULT-1:0]              mult_valid,
    output sys_defs::RS_ENTRY [NUM_MULT-1:0] mult_entry,
    output logic [NUM_BR-1:0]                br_valid,
    output sys_defs::RS_ENTRY [NUM_BR-1:0]   br_entry,
    output logic [NUM_MEM-1:0]               mem_valid,
    output sys_defs::RS_ENTRY [NUM_MEM-1:0]  mem_entry,
    output logic [NUM_ALU-1:0]               alu_avail,
    output logic [NUM_MULT-1:0]              mult_avail,
    output logic [NUM_BR-1:0]                branch_avail,
    output logic [NUM_MEM-1:0]               mem_avail,
    output logic                             alloc_error
);

    logic [NUM_ALU-1:0]               alu_take;
    logic [NUM_MULT-1:0]              mult_take;
    logic [NUM_BR-1:0]                br_take;
    logic [NUM_MEM-1:0]               mem_take;
    sys_defs::RS_ENTRY [NUM_ALU-1:0]  alu_pick;
    sys_defs::RS_ENTRY [NUM_MULT-1:0] mult_pick;
    sys_defs::RS_ENTRY [NUM_BR-1:0]   br_pick;
    sys_defs::RS_ENTRY [NUM_MEM-1:0]  mem_pick;
    logic                             found;
    logic                             drop;

    // ALU and branch units are fully pipelined and always accept work.
    assign alu_avail    = '1;
    assign branch_avail = '1;

    // Slot-order scan: each valid slot claims the lowest free unit of its class.
    always_comb begin
        alu_take  = '0;
        mult_take = '0;
        br_take   = '0;
        mem_take  = '0;
        alu_pick  = '0;
        mult_pick = '0;
        br_pick   = '0;
        mem_pick  = '0;
        found     = 1'b0;
        drop      = 1'b0;
        for (int s = 0; s < N; s++) begin
            found = 1'b0;
            if (issue_valid[s] && !mispredict) begin
                case (issued_entries[s].cat)
                    sys_defs::CAT_ALU, sys_defs::CAT_CSR: begin
                        for (int u = 0; u < NUM_ALU; u++) begin
                            if (!found && alu_avail[u] && !alu_take[u]) begin
                                alu_take[u] = 1'b1;
                                alu_pick[u] = issued_entries[s];
                                found       = 1'b1;
                            end
                        end
                    end
                    sys_defs::CAT_MULT: begin
                        for (int u = 0; u < NUM_MULT; u++) begin
                            if (!found && mult_avail[u] && !mult_take[u]) begin
                                mult_take[u] = 1'b1;
                                mult_pick[u] = issued_entries[s];
                                found        = 1'b1;
                            end
                        end
                    end
                    sys_defs::CAT_BRANCH: begin
                        for (int u = 0; u < NUM_BR; u++) begin
                            if (!found && branch_avail[u] && !br_take[u]) begin
                                br_take[u] = 1'b1;
                                br_pick[u] = issued_entries[s];
                                found      = 1'b1;
                            end
                        end
                    end
                    sys_defs::CAT_MEM: begin
                        for (int u = 0; u < NUM_MEM; u++) begin
                            if (!found && mem_avail[u] && !mem_take[u]) begin
                                mem_take[u] = 1'b1;
                                mem_pick[u] = issued_entries[s];
                                found       = 1'b1;
                            end
                        end
                    end
                    default: found = 1'b0;
                endcase
                if (!found) begin
                    drop = 1'b1;
                end
            end
        end
    end

    // Request registers: valids pulse for one cycle, entries load on allocation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_valid   <= '0;
            mult_valid  <= '0;
            br_valid    <= '0;
            mem_valid   <= '0;
            alu_entry   <= '0;
            mult_entry  <= '0;
            br_entry    <= '0;
            mem_entry   <= '0;
            alloc_error <= 1'b0;
        end else begin
            alu_valid   <= alu_take;
            mult_valid  <= mult_take;
            br_valid    <= br_take;
            mem_valid   <= mem_take;
            alloc_error <= drop;
            for (int u = 0; u < NUM_ALU; u++) begin
                if (alu_take[u]) alu_entry[u] <= alu_pick[u];
            end
            for (int u = 0; u < NUM_MULT; u++) begin
                if (mult_take[u]) mult_entry[u] <= mult_pick[u];
            end
            for (int u = 0; u < NUM_BR; u++) begin
                if (br_take[u]) br_entry[u] <= br_pick[u];
            end
            for (int u = 0; u < NUM_MEM; u++) begin
                if (mem_take[u]) mem_entry[u] <= mem_pick[u];
            end
        end
    end

    // One occupancy tracker per multiplier and per memory unit.
    for (genvar i = 0; i < NUM_MULT; i++) begin : g_mult
        fu_busy_tracker #(.IS_MULT(1'b1), .LAT(MULT_LAT)) u_trk (
            .clock (clock),
            .reset (reset),
            .alloc (mult_take[i]),
            .flush (mispredict),
            .done  (1'b0),
            .avail (mult_avail[i])
        );
    end

    for (genvar i = 0; i < NUM_MEM; i++) begin : g_mem
        fu_busy_tracker #(.IS_MULT(1'b0), .LAT(1)) u_trk (
            .clock (clock),
            .reset (reset),
            .alloc (mem_take[i]),
            .flush (mispredict),
            .done  (mem_done[i]),
            .avail (mem_avail[i])
        );
    end

endmodule

// File: tb/tb_issue_fu_alloc.sv
// Directed bench for issue_fu_alloc: a vector table applied from a clean
// reset, followed by multi-cycle sequences for MULT/MEM occupancy,
// mispredict squash and mid-operation reset.
module tb_issue_fu_alloc;
  import sys_defs::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        issue_valid = '0;
  RS_ENTRY [2:0]     issued_entries = '0;
  logic              mispredict = 1'b0;
  logic [0:0]        mem_done = '0;
  logic [2:0]        alu_valid;
  RS_ENTRY [2:0]     alu_entry;
  logic [0:0]        mult_valid;
  RS_ENTRY [0:0]     mult_entry;
  logic [0:0]        br_valid;
  RS_ENTRY [0:0]     br_entry;
  logic [0:0]        mem_valid;
  RS_ENTRY [0:0]     mem_entry;
  logic [2:0]        alu_avail;
  logic [0:0]        mult_avail;
  logic [0:0]        branch_avail;
  logic [0:0]        mem_avail;
  logic              alloc_error;

  int errors = 0;
  int checks = 0;

  issue_fu_alloc dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issued_entries (issued_entries),
    .mispredict     (mispredict),
    .mem_done       (mem_done),
    .alu_valid      (alu_valid),
    .alu_entry      (alu_entry),
    .mult_valid     (mult_valid),
    .mult_entry     (mult_entry),
    .br_valid       (br_valid),
    .br_entry       (br_entry),
    .mem_valid      (mem_valid),
    .mem_entry      (mem_entry),
    .alu_avail      (alu_avail),
    .mult_avail     (mult_avail),
    .branch_avail   (branch_avail),
    .mem_avail      (mem_avail),
    .alloc_error    (alloc_error)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]      iv;
    RS_ENTRY [2:0]   ent;
    logic [2:0]      e_alu;
    logic [2:0][7:0] e_alu_tag;
    logic            e_mult;
    logic [7:0]      e_mult_tag;
    logic            e_br;
    logic [7:0]      e_br_tag;
    logic            e_mem;
    logic [7:0]      e_mem_tag;
    logic            e_err;
  } vec_t;

  vec_t vecs[7];

  function automatic RS_ENTRY mk(input fu_cat_e c, input logic [7:0] t);
    RS_ENTRY e;
    e.cat = c;
    e.tag = t;
    return e;
  endfunction

  function automatic logic [32:0] ents(input RS_ENTRY e0, input RS_ENTRY e1, input RS_ENTRY e2);
    return {e2, e1, e0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [2:0] iv, input logic [32:0] e, input logic mp);
    issue_valid    = iv;
    issued_entries = e;
    mispredict     = mp;
  endtask

  task automatic idle();
    issue_valid = '0;
    mispredict  = 1'b0;
    mem_done    = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  initial begin
    // table: each vector applied one cycle after a fresh reset
    vecs[0] = '{3'b111, ents(mk(CAT_ALU, 8'd10), mk(CAT_ALU, 8'd11), mk(CAT_ALU, 8'd12)),
                3'b111, {8'd12, 8'd11, 8'd10}, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0};
    vecs[1] = '{3'b101, ents(mk(CAT_ALU, 8'd20), mk(CAT_ALU, 8'd21), mk(CAT_CSR, 8'd22)),
                3'b011, {8'd0, 8'd22, 8'd20}, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0};
    vecs[2] = '{3'b111, ents(mk(CAT_MULT, 8'd30), mk(CAT_BRANCH, 8'd31), mk(CAT_MEM, 8'd32)),
                3'b000, {8'd0, 8'd0, 8'd0}, 1'b1, 8'd30, 1'b1, 8'd31, 1'b1, 8'd32, 1'b0};
    vecs[3] = '{3'b111, ents(mk(CAT_MULT, 8'd40), mk(CAT_MULT, 8'd41), mk(CAT_ALU, 8'd42)),
                3'b001, {8'd0, 8'd0, 8'd42}, 1'b1, 8'd40, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1};
    vecs[4] = '{3'b011, ents(mk(CAT_BRANCH, 8'd50), mk(CAT_BRANCH, 8'd51), mk(CAT_ALU, 8'd0)),
                3'b000, {8'd0, 8'd0, 8'd0}, 1'b0, 8'd0, 1'b1, 8'd50, 1'b0, 8'd0, 1'b1};
    vecs[5] = '{3'b000, ents(mk(CAT_MULT, 8'd55), mk(CAT_MEM, 8'd56), mk(CAT_ALU, 8'd57)),
                3'b000, {8'd0, 8'd0, 8'd0}, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0};
    vecs[6] = '{3'b111, ents(mk(CAT_MEM, 8'd60), mk(CAT_MEM, 8'd61), mk(CAT_BRANCH, 8'd62)),
                3'b000, {8'd0, 8'd0, 8'd0}, 1'b0, 8'd0, 1'b1, 8'd62, 1'b1, 8'd60, 1'b1};

    // reset state
    #7;
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_mult_valid", 32'(mult_valid), 32'd0);
    chk("rst_alloc_error", 32'(alloc_error), 32'd0);
    chk("rst_alu_avail", 32'(alu_avail), 32'h7);
    chk("rst_mult_avail", 32'(mult_avail), 32'd1);
    chk("rst_branch_avail", 32'(branch_avail), 32'd1);
    chk("rst_mem_avail", 32'(mem_avail), 32'd1);
    chk("rst_alu_entry", 32'(alu_entry), 32'd0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      drive(vecs[v].iv, vecs[v].ent, 1'b0);
      step();
      chk($sformatf("v%0d_alu_valid", v), 32'(alu_valid), 32'(vecs[v].e_alu));
      for (int u = 0; u < 3; u++) begin
        if (vecs[v].e_alu[u])
          chk($sformatf("v%0d_alu_tag%0d", v, u), 32'(alu_entry[u].tag), 32'(vecs[v].e_alu_tag[u]));
      end
      chk($sformatf("v%0d_mult_valid", v), 32'(mult_valid), 32'(vecs[v].e_mult));
      if (vecs[v].e_mult) chk($sformatf("v%0d_mult_tag", v), 32'(mult_entry[0].tag), 32'(vecs[v].e_mult_tag));
      chk($sformatf("v%0d_br_valid", v), 32'(br_valid), 32'(vecs[v].e_br));
      if (vecs[v].e_br) chk($sformatf("v%0d_br_tag", v), 32'(br_entry[0].tag), 32'(vecs[v].e_br_tag));
      chk($sformatf("v%0d_mem_valid", v), 32'(mem_valid), 32'(vecs[v].e_mem));
      if (vecs[v].e_mem) chk($sformatf("v%0d_mem_tag", v), 32'(mem_entry[0].tag), 32'(vecs[v].e_mem_tag));
      chk($sformatf("v%0d_alloc_error", v), 32'(alloc_error), 32'(vecs[v].e_err));
      chk($sformatf("v%0d_mult_avail", v), 32'(mult_avail), 32'(!vecs[v].e_mult));
      chk($sformatf("v%0d_mem_avail", v), 32'(mem_avail), 32'(!vecs[v].e_mem));
      chk($sformatf("v%0d_alu_avail", v), 32'(alu_avail), 32'h7);
    end

    // MULT occupancy: issued in cycle t, busy t+1..t+4, free at t+5
    do_reset();
    drive(3'b001, ents(mk(CAT_MULT, 8'd90), mk(CAT_ALU, 8'd0), mk(CAT_ALU, 8'd0)), 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("mult_seq_valid_t%0d", k), 32'(mult_valid), 32'(k == 1));
      chk($sformatf("mult_seq_avail_t%0d", k), 32'(mult_avail), 32'(k == 5));
    end
    // second MULT slot dropped, error pulses for one cycle only
    drive(3'b011, ents(mk(CAT_MULT, 8'd91), mk(CAT_MULT, 8'd92), mk(CAT_ALU, 8'd0)), 1'b0);
    step();
    chk("mult_drop_tag", 32'(mult_entry[0].tag), 32'd91);
    chk("mult_drop_err", 32'(alloc_error), 32'd1);
    step();
    chk("mult_drop_err_clear", 32'(alloc_error), 32'd0);
    chk("mult_drop_valid_clear", 32'(mult_valid), 32'd0);

    // MEM busy until the edge after mem_done
    do_reset();
    drive(3'b001, ents(mk(CAT_MEM, 8'd100), mk(CAT_ALU, 8'd0), mk(CAT_ALU, 8'd0)), 1'b0);
    step();
    chk("mem_seq_valid", 32'(mem_valid), 32'd1);
    chk("mem_seq_avail0", 32'(mem_avail), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("mem_seq_busy%0d", k), 32'(mem_avail), 32'd0);
    end
    drive(3'b001, ents(mk(CAT_MEM, 8'd101), mk(CAT_ALU, 8'd0), mk(CAT_ALU, 8'd0)), 1'b0);
    mem_done = 1'b1;
    #1;
    chk("mem_seq_avail_during_done", 32'(mem_avail), 32'd0);
    step();
    chk("mem_busy_issue_err", 32'(alloc_error), 32'd1);
    chk("mem_busy_issue_valid", 32'(mem_valid), 32'd0);
    chk("mem_seq_avail_after", 32'(mem_avail), 32'd1);
    mem_done = 1'b1;
    step();
    chk("mem_idle_done_ignored", 32'(mem_avail), 32'd1);

    // mispredict with MULT cnt=3 and MEM busy
    do_reset();
    drive(3'b011, ents(mk(CAT_MULT, 8'd110), mk(CAT_MEM, 8'd111), mk(CAT_ALU, 8'd0)), 1'b0);
    step();
    drive(3'b001, ents(mk(CAT_ALU, 8'd112), mk(CAT_ALU, 8'd0), mk(CAT_ALU, 8'd0)), 1'b0);
    step();
    chk("mp_pre_alu_valid", 32'(alu_valid), 32'd1);
    chk("mp_pre_mult_avail", 32'(mult_avail), 32'd0);
    drive(3'b011, ents(mk(CAT_ALU, 8'd113), mk(CAT_BRANCH, 8'd114), mk(CAT_ALU, 8'd0)), 1'b1);
    step();
    chk("mp_alu_valid", 32'(alu_valid), 32'd0);
    chk("mp_br_valid", 32'(br_valid), 32'd0);
    chk("mp_mult_valid", 32'(mult_valid), 32'd0);
    chk("mp_mem_valid", 32'(mem_valid), 32'd0);
    chk("mp_mult_avail", 32'(mult_avail), 32'd1);
    chk("mp_mem_avail", 32'(mem_avail), 32'd0);
    chk("mp_alloc_error", 32'(alloc_error), 32'd0);
    step();
    chk("mp_mem_still_busy", 32'(mem_avail), 32'd0);
    mem_done = 1'b1;
    step();
    chk("mp_mem_released", 32'(mem_avail), 32'd1);

    // reset asserted mid-MULT
    do_reset();
    drive(3'b011, ents(mk(CAT_MULT, 8'd120), mk(CAT_ALU, 8'd121), mk(CAT_ALU, 8'd0)), 1'b0);
    step();
    chk("mr_pre_mult_valid", 32'(mult_valid), 32'd1);
    chk("mr_pre_mult_avail", 32'(mult_avail), 32'd0);
    #2;
    reset = 1'b0;
    drive(3'b111, ents(mk(CAT_ALU, 8'd122), mk(CAT_ALU, 8'd123), mk(CAT_MULT, 8'd124)), 1'b0);
    #1;
    chk("mr_alu_valid", 32'(alu_valid), 32'd0);
    chk("mr_mult_valid", 32'(mult_valid), 32'd0);
    chk("mr_alu_entry", 32'(alu_entry), 32'd0);
    chk("mr_mult_avail", 32'(mult_avail), 32'd1);
    chk("mr_mem_avail", 32'(mem_avail), 32'd1);
    @(negedge clock);
    idle();
    reset = 1'b1;
    step();
    chk("mr_post_alu_valid", 32'(alu_valid), 32'd0);
    chk("mr_post_mult_valid", 32'(mult_valid), 32'd0);
    chk("mr_post_mult_avail", 32'(mult_avail), 32'd1);
    drive(3'b001, ents(mk(CAT_ALU, 8'd125), mk(CAT_ALU, 8'd0), mk(CAT_ALU, 8'd0)), 1'b0);
    step();
    chk("mr_resume_alu_valid", 32'(alu_valid), 32'd1);
    chk("mr_resume_alu_tag", 32'(alu_entry[0].tag), 32'd125);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
